// File: rtl/alu_pkg.sv
// Shared encodings for the sequential Hack ALU: operation modes and controller states.
package alu_pkg;

   typedef enum logic [1:0] {
      MODE_HACK = 2'b00,
      MODE_MUL  = 2'b01,
      MODE_SHL  = 2'b10,
      MODE_SAR  = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/hack_alu_core.sv
// Combinational zx/nx/zy/ny/f/no datapath of the Hack ALU, widened to WIDTH bits,
// with the carry-out of the adder exposed.
module hack_alu_core #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             zx,
   input  logic             nx,
   input  logic             zy,
   input  logic             ny,
   input  logic             f,
   input  logic             no,
   output logic [WIDTH-1:0] result,
   output logic             cy
);

   logic [WIDTH-1:0] x_z, x_n, y_z, y_n, f_val;
   logic [WIDTH:0]   sum;

   // NOTE: every output of this always_comb gets a value on every path, so no latch is inferred.
   always_comb begin
      x_z    = zx ? '0 : x;
      x_n    = nx ? ~x_z : x_z;
      y_z    = zy ? '0 : y;
      y_n    = ny ? ~y_z : y_z;
      sum    = {1'b0, x_n} + {1'b0, y_n};
      f_val  = f ? sum[WIDTH-1:0] : (x_n & y_n);
      result = no ? ~f_val : f_val;
      // Carry is taken from the adder before the output inversion.
      cy     = f & sum[WIDTH];
   end

endmodule

// File: rtl/alu_seq.sv
// Handshaked, registered Hack ALU with an iterative shift-add multiplier and 1-bit shifts.
// Latency-1 modes compute at the accept edge; MUL iterates WIDTH cycles before DONE.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             i_Clk,
   input  logic             i_Reset,
   input  logic             i_Valid,
   output logic             o_Ready,
   input  logic [WIDTH-1:0] i_X,
   input  logic [WIDTH-1:0] i_Y,
   input  logic [1:0]       i_Mode,
   input  logic             i_ZX,
   input  logic             i_NX,
   input  logic             i_ZY,
   input  logic             i_NY,
   input  logic             i_F,
   input  logic             i_NO,
   output logic             o_Valid,
   input  logic             i_Ready,
   output logic [WIDTH-1:0] o_Result,
   output logic             o_ZR,
   output logic             o_NG,
   output logic             o_CY
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   state_e             state_q, state_d;
   mode_e              mode_in;
   logic               accept;
   logic               mul_last;

   logic [CNT_W-1:0]   cnt_q;
   logic [2*WIDTH-1:0] acc_q, acc_next, mcand_q;
   logic [WIDTH-1:0]   mplier_q;

   logic [WIDTH-1:0]   core_result;
   logic               core_cy;
   logic [WIDTH-1:0]   load_result;
   logic               load_cy;
   logic               load_en;

   assign mode_in  = mode_e'(i_Mode);
   assign o_Ready  = (state_q == ST_IDLE) && !i_Reset;
   assign o_Valid  = (state_q == ST_DONE);
   assign accept   = i_Valid && o_Ready;
   assign mul_last = (state_q == ST_MUL) && (cnt_q == CNT_W'(WIDTH - 1));
   assign acc_next = mplier_q[0] ? acc_q + mcand_q : acc_q;

   hack_alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .x      (i_X),
      .y      (i_Y),
      .zx     (i_ZX),
      .nx     (i_NX),
      .zy     (i_ZY),
      .ny     (i_NY),
      .f      (i_F),
      .no     (i_NO),
      .result (core_result),
      .cy     (core_cy)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept)   state_d = (mode_in == MODE_MUL) ? ST_MUL : ST_DONE;
         ST_MUL:  if (mul_last) state_d = ST_DONE;
         ST_DONE: if (i_Ready)  state_d = ST_IDLE;
         default:               state_d = ST_IDLE;
      endcase
   end

   // NOTE: multiplier datapath registers carry no reset; they are always reloaded at accept.
   always_ff @(posedge i_Clk) begin
      if (accept) begin
         acc_q    <= '0;
         mcand_q  <= {{WIDTH{1'b0}}, i_X};
         mplier_q <= i_Y;
         cnt_q    <= '0;
      end else if (state_q == ST_MUL) begin
         acc_q    <= acc_next;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + CNT_W'(1);
      end
   end

   // Selects what the output registers capture: an immediate result at accept, or the final product.
   always_comb begin
      load_en     = 1'b0;
      load_result = '0;
      load_cy     = 1'b0;
      if (mul_last) begin
         load_en     = 1'b1;
         load_result = acc_next[WIDTH-1:0];
         load_cy     = |acc_next[2*WIDTH-1:WIDTH];
      end else if (accept) begin
         case (mode_in)
            MODE_HACK: begin
               load_en     = 1'b1;
               load_result = core_result;
               load_cy     = core_cy;
            end
            MODE_SHL: begin
               load_en     = 1'b1;
               load_result = {i_X[WIDTH-2:0], 1'b0};
               load_cy     = i_X[WIDTH-1];
            end
            MODE_SAR: begin
               load_en     = 1'b1;
               load_result = {i_X[WIDTH-1], i_X[WIDTH-1:1]};
               load_cy     = i_X[0];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         o_Result <= '0;
         o_ZR     <= 1'b0;
         o_NG     <= 1'b0;
         o_CY     <= 1'b0;
      end else if (load_en) begin
         o_Result <= load_result;
         o_ZR     <= (load_result == '0);
         o_NG     <= load_result[WIDTH-1];
         o_CY     <= load_cy;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): directed vector table, handshake corner
// sequences, and randomized operations against an arithmetic reference model.
module tb_alu_seq;
   import alu_pkg::*;

   localparam int W = 16;
   localparam int unsigned MOD  = 65536;
   localparam int unsigned MASK = 65535;

   logic          clk = 1'b0;
   logic          i_Reset, i_Valid, i_Ready;
   logic          o_Ready, o_Valid;
   logic [W-1:0]  i_X, i_Y, o_Result;
   logic [1:0]    i_Mode;
   logic          i_ZX, i_NX, i_ZY, i_NY, i_F, i_NO;
   logic          o_ZR, o_NG, o_CY;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      string       name;
      logic [1:0]  mode;
      logic [15:0] x;
      logic [15:0] y;
      logic [5:0]  c;
      logic [15:0] er;
      bit          ecy;
      int          elat;
   } vec_t;

   vec_t vecs[12];

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W)) dut (
      .i_Clk    (clk),
      .i_Reset  (i_Reset),
      .i_Valid  (i_Valid),
      .o_Ready  (o_Ready),
      .i_X      (i_X),
      .i_Y      (i_Y),
      .i_Mode   (i_Mode),
      .i_ZX     (i_ZX),
      .i_NX     (i_NX),
      .i_ZY     (i_ZY),
      .i_NY     (i_NY),
      .i_F      (i_F),
      .i_NO     (i_NO),
      .o_Valid  (o_Valid),
      .i_Ready  (i_Ready),
      .o_Result (o_Result),
      .o_ZR     (o_ZR),
      .o_NG     (o_NG),
      .o_CY     (o_CY)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   // Reference model built from the arithmetic rules, not from the datapath structure.
   function automatic void ref_model(input logic [1:0] mode, input int unsigned x, input int unsigned y,
                                     input logic [5:0] c, output int unsigned r, output bit cy);
      int unsigned xa, ya, s;
      longint unsigned p;
      r  = 0;
      cy = 0;
      case (mode)
         2'b00: begin
            xa = c[5] ? 0 : x;
            if (c[4]) xa = MASK - xa;
            ya = c[3] ? 0 : y;
            if (c[2]) ya = MASK - ya;
            if (c[1]) begin
               s  = xa + ya;
               cy = (s >= MOD);
               r  = s % MOD;
            end else begin
               r = xa & ya;
            end
            if (c[0]) r = MASK - r;
         end
         2'b01: begin
            p  = longint'(x) * longint'(y);
            r  = int'(p % MOD);
            cy = (p >= MOD);
         end
         2'b10: begin
            r  = (x * 2) % MOD;
            cy = (x >= 32768);
         end
         default: begin
            r  = x / 2 + ((x >= 32768) ? 32768 : 0);
            cy = (x % 2 == 1);
         end
      endcase
   endfunction

   task automatic run_op(input string name, input logic [1:0] mode, input logic [15:0] x,
                         input logic [15:0] y, input logic [5:0] c, input logic [15:0] er,
                         input bit ecy, input int elat, input bit release_done);
      int lat;
      int k;
      k = 0;
      while (!o_Ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check({name, " ready_before"}, o_Ready, 1);
      i_Valid = 1'b1;
      i_Mode  = mode;
      i_X     = x;
      i_Y     = y;
      {i_ZX, i_NX, i_ZY, i_NY, i_F, i_NO} = c;
      @(negedge clk);
      i_Valid = 1'b0;
      i_X     = 16'($urandom);
      i_Y     = 16'($urandom);
      {i_ZX, i_NX, i_ZY, i_NY, i_F, i_NO} = 6'($urandom);
      lat = 1;
      while (!o_Valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check({name, " latency"}, lat, elat);
      check({name, " result"}, o_Result, er);
      check({name, " zr"}, o_ZR, (er == 16'h0000));
      check({name, " ng"}, o_NG, er[15]);
      check({name, " cy"}, o_CY, ecy);
      if (release_done) begin
         i_Ready = 1'b1;
         @(negedge clk);
         i_Ready = 1'b0;
         check({name, " ready_after"}, o_Ready, 1);
         check({name, " valid_drop"}, o_Valid, 0);
         check({name, " result_held"}, o_Result, er);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned r;
      bit cy;
      bit seen_valid;
      logic [1:0]  m;
      logic [15:0] rx, ry;
      logic [5:0]  rc;

      vecs[0]  = '{"d_plus_1",  2'b00, 16'd5,      16'h1234, 6'b011111, 16'h0006, 1'b1, 1};
      vecs[1]  = '{"x_minus_y", 2'b00, 16'd3,      16'd3,    6'b010011, 16'h0000, 1'b0, 1};
      vecs[2]  = '{"x_minus_y2",2'b00, 16'd2,      16'd3,    6'b010011, 16'hFFFF, 1'b1, 1};
      vecs[3]  = '{"mul_300",   2'b01, 16'd300,    16'd300,  6'b000000, 16'h5F90, 1'b1, 17};
      vecs[4]  = '{"mul_ffff",  2'b01, 16'hFFFF,   16'd1,    6'b111111, 16'hFFFF, 1'b0, 17};
      vecs[5]  = '{"sar_8001",  2'b11, 16'h8001,   16'h0000, 6'b000000, 16'hC000, 1'b1, 1};
      vecs[6]  = '{"sar_0001",  2'b11, 16'h0001,   16'h0000, 6'b000000, 16'h0000, 1'b1, 1};
      vecs[7]  = '{"shl_8001",  2'b10, 16'h8001,   16'h0000, 6'b000000, 16'h0002, 1'b1, 1};
      vecs[8]  = '{"and_xy",    2'b00, 16'hF0F0,   16'h3C3C, 6'b000000, 16'h3030, 1'b0, 1};
      vecs[9]  = '{"mul_zero",  2'b01, 16'h0000,   16'h1234, 6'b000000, 16'h0000, 1'b0, 17};
      vecs[10] = '{"const_0",   2'b00, 16'hABCD,   16'h1357, 6'b101010, 16'h0000, 1'b0, 1};
      vecs[11] = '{"const_m1",  2'b00, 16'hABCD,   16'h1357, 6'b111010, 16'hFFFF, 1'b0, 1};

      i_Reset = 1'b1;
      i_Valid = 1'b0;
      i_Ready = 1'b0;
      i_X     = '0;
      i_Y     = '0;
      i_Mode  = 2'b00;
      {i_ZX, i_NX, i_ZY, i_NY, i_F, i_NO} = 6'b000000;

      repeat (3) @(negedge clk);
      check("rst ready", o_Ready, 0);
      check("rst valid", o_Valid, 0);
      check("rst result", o_Result, 0);
      check("rst flags", {o_ZR, o_NG, o_CY}, 3'b000);
      i_Reset = 1'b0;
      #1;
      check("rst release ready", o_Ready, 1);
      check("rst release valid", o_Valid, 0);
      @(negedge clk);

      foreach (vecs[i])
         run_op(vecs[i].name, vecs[i].mode, vecs[i].x, vecs[i].y, vecs[i].c,
                vecs[i].er, vecs[i].ecy, vecs[i].elat, 1'b1);

      // Backpressure: DONE holds result while requests keep arriving.
      run_op("bp_shl", 2'b10, 16'h1234, 16'h0000, 6'b000000, 16'h2468, 1'b0, 1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         i_Valid = 1'b1;
         i_Mode  = 2'($urandom);
         i_X     = 16'($urandom);
         i_Y     = 16'($urandom);
         @(negedge clk);
         check("bp valid", o_Valid, 1);
         check("bp ready", o_Ready, 0);
         check("bp result", o_Result, 16'h2468);
         check("bp flags", {o_ZR, o_NG, o_CY}, 3'b000);
      end
      i_Ready = 1'b1;
      @(negedge clk);
      i_Ready = 1'b0;
      i_Valid = 1'b0;
      check("bp release ready", o_Ready, 1);
      check("bp release valid", o_Valid, 0);
      check("bp release result", o_Result, 16'h2468);
      @(negedge clk);
      check("bp no accept", o_Valid, 0);

      // Reset in the eighth MUL cycle aborts the operation.
      i_Valid = 1'b1;
      i_Mode  = 2'b01;
      i_X     = 16'h1234;
      i_Y     = 16'h5678;
      @(negedge clk);
      i_Valid = 1'b0;
      repeat (7) @(negedge clk);
      check("abort mid valid", o_Valid, 0);
      i_Reset = 1'b1;
      #1;
      check("abort ready in reset", o_Ready, 0);
      @(negedge clk);
      check("abort valid", o_Valid, 0);
      check("abort result", o_Result, 0);
      check("abort flags", {o_ZR, o_NG, o_CY}, 3'b000);
      @(negedge clk);
      i_Reset = 1'b0;
      #1;
      check("abort release ready", o_Ready, 1);
      seen_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (o_Valid) seen_valid = 1'b1;
      end
      check("abort no valid", seen_valid, 0);
      check("abort result after", o_Result, 0);
      run_op("post_abort_shl", 2'b10, 16'h8001, 16'h0000, 6'b000000, 16'h0002, 1'b1, 1, 1'b1);

      // Randomized operations against the reference model.
      for (int i = 0; i < 30; i++) begin
         m  = 2'($urandom_range(0, 3));
         rx = (i % 7 == 0) ? 16'hFFFF : 16'($urandom);
         ry = (i % 5 == 0) ? 16'hFFFF : 16'($urandom);
         rc = 6'($urandom);
         ref_model(m, rx, ry, rc, r, cy);
         run_op($sformatf("rand%0d", i), m, rx, ry, rc, 16'(r), cy,
                (m == 2'b01) ? W + 1 : 1, 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the Hack combinational ALU.
- Registers the classic zx/nx/zy/ny/f/no datapath at configurable WIDTH.
- Adds a mode field for an iterative multiplier and 1-bit shifts, plus a carry/overflow flag.
- Sits between the CPU decode stage and the D/A/M write-back; the CPU stalls on o_Ready/o_Valid.

Parameters:
- WIDTH, 16, data width of operands, result and internal adder (must be >= 2).
- CNT_W, $clog2(WIDTH)+1, multiplier iteration counter width (derived; not to be overridden).

Ports:
- i_Clk  in  1  system clock; all state updates on rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Valid  in  1  operation request.
- o_Ready  out  1  block can accept a request this cycle.
- i_X  in  WIDTH  operand X.
- i_Y  in  WIDTH  operand Y.
- i_Mode  in  2  00 Hack op, 01 MUL, 10 SHL, 11 SAR.
- i_ZX, i_NX, i_ZY, i_NY, i_F, i_NO  in  1 each  Hack control bits; used only in mode 00.
- o_Valid  out  1  result and flags valid.
- i_Ready  in  1  consumer accepts the result.
- o_Result  out  WIDTH  registered result.
- o_ZR  out  1  result == 0.
- o_NG  out  1  result MSB.
- o_CY  out  1  carry / overflow / shifted-out bit.

Behaviour:
- Reset:
  - State goes to IDLE.
  - o_Valid, o_Result, o_ZR, o_NG and o_CY are all 0.
  - o_Ready is forced 0 while i_Reset is high and is 1 in the first cycle after release.
- States: IDLE, MUL, DONE. o_Ready = (state == IDLE) and not i_Reset. o_Valid = (state == DONE).
- Accept: a request is accepted on the edge where i_Valid && o_Ready. At that edge, i_X, i_Y, i_Mode and the control bits are latched. Inputs seen while not IDLE are ignored.
- Mode 00, Hack op:
  - x' = ZX ? 0 : X; then x' = NX ? ~x' : x'. Same for y' using ZY/NY.
  - f = F ? x'+y' (mod 2^WIDTH) : x' & y'; result = NO ? ~f : f.
  - o_CY = carry-out of x'+y' when F=1 (taken before NO); o_CY = 0 when F=0.
  - IDLE -> DONE. o_Valid rises the cycle after accept (latency 1).
- Mode 01, MUL:
  - Unsigned X*Y on raw operands; control bits are ignored.
  - Shift-add, one multiplier bit per cycle. IDLE -> MUL; stays in MUL for exactly WIDTH cycles, counter 0..WIDTH-1.
  - Then -> DONE. o_Valid rises WIDTH+1 cycles after accept.
  - o_Result = low WIDTH bits of the product. o_CY = 1 iff the high WIDTH bits are nonzero.
- Mode 10, SHL: result = X << 1, LSB = 0. o_CY = X[WIDTH-1]. Latency 1.
- Mode 11, SAR: result = arithmetic X >> 1, MSB replicated. o_CY = X[0]. Latency 1.
- Flags: o_ZR and o_NG always derive from the final result in all modes. They are registered together with o_Result.
- DONE:
  - o_Result and all flags are held stable while i_Ready = 0, for an unbounded time.
  - On i_Valid... no: on the edge where i_Ready = 1, go to IDLE. o_Valid drops the next cycle and o_Ready rises the same cycle.
  - Outputs keep their last values in IDLE; they are not cleared.
- Throughput: at most one op per 2 cycles for latency-1 modes. No accept is possible in DONE or MUL.
- Reset mid-MUL or in DONE: the operation is aborted, no o_Valid is produced, and all outputs follow the reset values.
- Simultaneous events: i_Reset has priority over the handshake. i_Valid in the same cycle as DONE&&i_Ready is not accepted, because o_Ready = 0 that cycle.
- The internal adder is WIDTH+1 bits to capture the carry. All other arithmetic is modulo 2^WIDTH.

Decomposition:
- Shared package alu_pkg holds:
  - the mode encodings MODE_HACK, MODE_MUL, MODE_SHL, MODE_SAR;
  - the state encodings ST_IDLE, ST_MUL, ST_DONE.
- One natural sub-module: hack_alu_core. It is a purely combinational, WIDTH-parametrised zx/nx/zy/ny/f/no datapath with a carry output. alu_seq instantiates it for mode 00 and owns the FSM, multiplier registers and output registers.

Test Plan (WIDTH=16):
- D+1 (mode 00; ZX0 NX1 ZY1 NY1 F1 NO1), X=5 -> o_Valid 1 cycle after accept; o_Result=0x0006, ZR=0, NG=0, CY=1.
- X-Y (ZX0 NX1 ZY0 NY0 F1 NO1), X=3, Y=3 -> o_Result=0x0000, ZR=1, NG=0. Repeat with X=2, Y=3 -> 0xFFFF, NG=1.
- MUL, X=300, Y=300 -> o_Valid exactly 17 cycles after accept; o_Result=0x5F90, CY=1. Also X=0xFFFF, Y=1 -> 0xFFFF, CY=0, NG=1.
- Backpressure: hold i_Ready=0 for 5 cycles in DONE with i_Valid=1 and changing operands -> o_Result and flags stable, o_Ready=0, no new accept. Then i_Ready=1 -> o_Ready=1 next cycle.
- Reset at cycle 8 of MUL -> o_Valid never asserts; outputs 0 during and after reset; o_Ready=1 in the first cycle after release; next SHL X=0x8001 -> 0x0002, CY=1.
- SAR, X=0x8001 -> o_Result=0xC000, NG=1, CY=1. SAR, X=0x0001 -> 0x0000, ZR=1, CY=1.
